hack_prog_loader: RTL

//  Writer side of the Hack instruction memory. Receives a framed program image

---
 rtl/hack_prog_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hack_prog_loader.sv
// hack_prog_loader: receives a framed Hack program image over a byte stream,
// writes it into the instruction RAM, and releases the CPU only after a
// complete image with a valid checksum has arrived.
module hack_prog_loader #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned LEN_W   = 16;
    // One extra bit so a full 2**ADDR_W image does not wrap the index.
    localparam int unsigned IDX_W   = ADDR_W + 1;
    localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   len_in;
    logic [7:0]         hi_byte;
    logic [7:0]         sum;
    logic [IDX_W-1:0]   index;
    logic               xfer;
    logic               waiting;

    assign xfer    = in_valid & in_ready;
    assign waiting = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign len_in  = {len[LEN_W-1:8], in_data};

    // Next-state logic for the frame parser.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (32'(len_in) > MAX_LEN)  state_nxt = S_ERROR;
                    else if (len_in == '0)      state_nxt = S_CHK;
                    else                        state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (xfer) state_nxt = S_DAT_LO;
            end
            S_DAT_LO: begin
                if (xfer) begin
                    if (32'(index) == 32'(len) - 32'd1) state_nxt = S_CHK;
                    else                                state_nxt = S_DAT_HI;
                end
            end
            S_CHK: begin
                if (xfer) state_nxt = (in_data == sum) ? S_DONE : S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and Moore outputs registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) ||
                        (state_nxt == S_DAT_HI) || (state_nxt == S_DAT_LO) ||
                        (state_nxt == S_CHK);
            cpu_hold <= (state_nxt != S_DONE);
            done     <= (state_nxt == S_DONE);
            error    <= (state_nxt == S_ERROR);
        end
    end

    // Datapath: length capture, checksum accumulation, word assembly and RAM write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len     <= '0;
            hi_byte <= '0;
            sum     <= '0;
            index   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (waiting) begin
                if (start) begin
                    sum   <= '0;
                    index <= '0;
                end
            end else if (xfer) begin
                case (state)
                    S_LEN_HI: begin
                        len[LEN_W-1:8] <= in_data;
                        sum            <= sum + in_data;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= in_data;
                        sum      <= sum + in_data;
                    end
                    S_DAT_HI: begin
                        hi_byte <= in_data;
                        sum     <= sum + in_data;
                    end
                    S_DAT_LO: begin
                        wr_en   <= 1'b1;
                        wr_addr <= index[ADDR_W-1:0];
                        wr_data <= DATA_W'({hi_byte, in_data});
                        index   <= index + IDX_W'(1);
                        sum     <= sum + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
